hazard_ctrl_unit: RTL and testbench

//  Pipeline control master that drives the hold/bubble inputs of the IF/ID and ID/EX stage registers
//  and the PC: load-use stall, taken-branch/jump flush, HALT drain, and debug run/step freeze.

---
 rtl/hazard_ctrl_unit_pkg.sv | 37 +++
 rtl/hazard_ctrl_unit_load_use_detect.sv | 24 ++
 rtl/hazard_ctrl_unit.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// default geometry and the stage-register control bundle.
package hazard_ctrl_unit_pkg;

    localparam int RBITS_DEF        = 5;
    localparam int CBITS_DEF        = 32;
    localparam int DRAIN_CYCLES_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } hcu_state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_if;
        logic flush_if;
        logic flush_id;
        logic stall_id;
    } hcu_ctrl_t;

    function automatic hcu_ctrl_t mk_ctrl(input logic stall_pc, input logic stall_if,
                                          input logic flush_if, input logic flush_id,
                                          input logic stall_id);
        hcu_ctrl_t c;
        c.stall_pc = stall_pc;
        c.stall_if = stall_if;
        c.flush_if = flush_if;
        c.flush_id = flush_id;
        c.stall_id = stall_id;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_load_use_detect.sv
// Combinational load-use hazard comparator: flags an ID-stage read of the
// register an EX-stage load is about to write (r0 never hazards).
module hazard_ctrl_unit_load_use_detect
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int RBITS = RBITS_DEF
) (
    input  logic [RBITS-1:0] ID_rs,
    input  logic [RBITS-1:0] ID_rt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             EX_memread,
    input  logic [RBITS-1:0] EX_rt,
    output logic             lu
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = ID_use_rs && (ID_rs == EX_rt);
    assign rt_hit_s = ID_use_rt && (ID_rt == EX_rt);
    assign lu       = EX_memread && (EX_rt != {RBITS{1'b0}}) && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline control master: drives PC / IF/ID / ID/EX hold and bubble controls
// for load-use stalls, branch flushes, HALT drain and debug run/step freezing.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int RBITS        = RBITS_DEF,
    parameter int CBITS        = CBITS_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [RBITS-1:0] ID_rs,
    input  logic [RBITS-1:0] ID_rt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             ID_branch_tkn,
    input  logic             ID_halt,
    input  logic             EX_memread,
    input  logic [RBITS-1:0] EX_rt,
    input  logic             i_dbg_run,
    input  logic             i_dbg_step,
    output logic             stallPC,
    output logic             stallIF,
    output logic             flushIF,
    output logic             flushID,
    output logic             stallID,
    output logic             o_halted,
    output logic             o_step_done,
    output logic [CBITS-1:0] o_cycles,
    output logic [CBITS-1:0] o_stalls
);

    localparam int DBITS = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DBITS-1:0] DRAIN_LOAD = DBITS'(DRAIN_CYCLES);
    localparam logic [DBITS-1:0] DRAIN_LAST = DBITS'(1);
    localparam logic [CBITS-1:0] CNT_ONE    = CBITS'(1);

    hcu_state_e       state_r;
    hcu_state_e       state_nxt_s;
    logic [DBITS-1:0] drain_r;
    logic [DBITS-1:0] drain_nxt_s;
    logic             step_done_nxt_s;
    logic             stall_inc_s;
    logic             active_s;
    logic             lu_s;
    hcu_ctrl_t        ctrl_s;
    logic             halted_r;
    logic             step_done_r;
    logic [CBITS-1:0] cycles_r;
    logic [CBITS-1:0] stalls_r;

    hazard_ctrl_unit_load_use_detect #(.RBITS(RBITS)) u_lu (
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .ID_use_rs  (ID_use_rs),
        .ID_use_rt  (ID_use_rt),
        .EX_memread (EX_memread),
        .EX_rt      (EX_rt),
        .lu         (lu_s)
    );

    // Next-state, drain countdown and stage-register controls.
    always_comb begin
        ctrl_s          = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        state_nxt_s     = state_r;
        drain_nxt_s     = drain_r;
        step_done_nxt_s = 1'b0;
        stall_inc_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_dbg_run) begin
                    state_nxt_s = ST_RUN;
                end else if (i_dbg_step) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN, ST_STEP: begin
                // Load-use outranks HALT and branch: the stalled instruction is re-decoded next cycle.
                if (lu_s) begin
                    ctrl_s      = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
                    stall_inc_s = 1'b1;
                end else if (ID_halt) begin
                    ctrl_s      = mk_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                end else if (ID_branch_tkn) begin
                    ctrl_s      = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                end else begin
                    ctrl_s      = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                if (ID_halt && !lu_s) begin
                    state_nxt_s = ST_DRAIN;
                    drain_nxt_s = DRAIN_LOAD;
                end else if (state_r == ST_STEP) begin
                    state_nxt_s     = ST_IDLE;
                    step_done_nxt_s = 1'b1;
                end else if (!i_dbg_run) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                ctrl_s      = mk_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                drain_nxt_s = drain_r - DRAIN_LAST;
                if (drain_r == DRAIN_LAST) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                state_nxt_s = ST_HALTED;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign active_s = (state_r == ST_RUN) || (state_r == ST_STEP) || (state_r == ST_DRAIN);

    // State, drain counter, status flags and saturating statistics.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            drain_r     <= {DBITS{1'b0}};
            halted_r    <= 1'b0;
            step_done_r <= 1'b0;
            cycles_r    <= {CBITS{1'b0}};
            stalls_r    <= {CBITS{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            drain_r     <= drain_nxt_s;
            halted_r    <= (state_nxt_s == ST_HALTED);
            step_done_r <= step_done_nxt_s;
            if (active_s && !(&cycles_r)) begin
                cycles_r <= cycles_r + CNT_ONE;
            end else begin
                cycles_r <= cycles_r;
            end
            if (stall_inc_s && !(&stalls_r)) begin
                stalls_r <= stalls_r + CNT_ONE;
            end else begin
                stalls_r <= stalls_r;
            end
        end
    end

    assign stallPC     = ctrl_s.stall_pc;
    assign stallIF     = ctrl_s.stall_if;
    assign flushIF     = ctrl_s.flush_if;
    assign flushID     = ctrl_s.flush_id;
    assign stallID     = ctrl_s.stall_id;
    assign o_halted    = halted_r;
    assign o_step_done = step_done_r;
    assign o_cycles    = cycles_r;
    assign o_stalls    = stalls_r;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit: freeze, load-use, branch,
// step, HALT drain and reset-in-drain scenarios with hand-computed expectations.
module tb_hazard_ctrl_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        ID_use_rs, ID_use_rt, ID_branch_tkn, ID_halt, EX_memread;
    logic        i_dbg_run, i_dbg_step;
    logic        stallPC, stallIF, flushIF, flushID, stallID;
    logic        o_halted, o_step_done;
    logic [31:0] o_cycles, o_stalls;

    int checks = 0;
    int errors = 0;

    hazard_ctrl_unit dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .ID_branch_tkn(ID_branch_tkn), .ID_halt(ID_halt),
        .EX_memread(EX_memread), .EX_rt(EX_rt),
        .i_dbg_run(i_dbg_run), .i_dbg_step(i_dbg_step),
        .stallPC(stallPC), .stallIF(stallIF), .flushIF(flushIF), .flushID(flushID),
        .stallID(stallID), .o_halted(o_halted), .o_step_done(o_step_done),
        .o_cycles(o_cycles), .o_stalls(o_stalls)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
        ID_use_rs = 1'b0; ID_use_rt = 1'b0; ID_branch_tkn = 1'b0; ID_halt = 1'b0;
        EX_memread = 1'b0; i_dbg_run = 1'b0; i_dbg_step = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] ex_rt, input logic [4:0] rs);
        EX_memread = 1'b1; EX_rt = ex_rt; ID_rs = rs; ID_use_rs = 1'b1;
    endtask

    task automatic clear_load_use();
        EX_memread = 1'b0; EX_rt = 5'd0; ID_rs = 5'd0; ID_use_rs = 1'b0;
        ID_rt = 5'd0; ID_use_rt = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({stallPC, stallIF, stallID, flushIF, flushID} !== 5'b11100) begin
                errors++;
                $display("FAIL reset_ctrl cyc %0d got %b exp 11100", i,
                         {stallPC, stallIF, stallID, flushIF, flushID});
            end
            checks++;
            if (o_cycles !== 32'd0 || o_halted !== 1'b0 || o_step_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_status cyc %0d cycles %0d halted %b step_done %b exp 0 0 0",
                         i, o_cycles, o_halted, o_step_done);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        i_dbg_run = 1'b1;
        tick();
        set_load_use(5'd8, 5'd8);
        #1;
        checks++;
        if ({stallPC, stallIF, flushID, stallID, flushIF} !== 5'b11100) begin
            errors++;
            $display("FAIL lu_ctrl got %b exp 11100", {stallPC, stallIF, flushID, stallID, flushIF});
        end
        tick();
        clear_load_use();
        #1;
        checks++;
        if ({stallPC, stallIF, flushID, stallID, flushIF} !== 5'b00000) begin
            errors++;
            $display("FAIL lu_release got %b exp 00000", {stallPC, stallIF, flushID, stallID, flushIF});
        end
        checks++;
        if (o_stalls !== 32'd1 || o_cycles !== 32'd1) begin
            errors++;
            $display("FAIL lu_counts stalls %0d cycles %0d exp 1 1", o_stalls, o_cycles);
        end
    endtask

    task automatic test_no_stall();
        set_load_use(5'd0, 5'd0);
        #1;
        checks++;
        if ({stallPC, flushID} !== 2'b00) begin
            errors++;
            $display("FAIL lu_r0 got %b exp 00", {stallPC, flushID});
        end
        clear_load_use();
        EX_memread = 1'b1; EX_rt = 5'd8; ID_rt = 5'd8; ID_use_rt = 1'b0;
        #1;
        checks++;
        if ({stallPC, flushID} !== 2'b00) begin
            errors++;
            $display("FAIL lu_unused_rt got %b exp 00", {stallPC, flushID});
        end
        ID_use_rt = 1'b1;
        #1;
        checks++;
        if ({stallPC, flushID, stallID} !== 3'b110) begin
            errors++;
            $display("FAIL lu_rt got %b exp 110", {stallPC, flushID, stallID});
        end
        tick();
        clear_load_use();
        #1;
        checks++;
        if (o_stalls !== 32'd2) begin
            errors++;
            $display("FAIL lu_rt_count stalls %0d exp 2", o_stalls);
        end
    endtask

    task automatic test_lu_branch();
        set_load_use(5'd3, 5'd3);
        ID_branch_tkn = 1'b1;
        #1;
        checks++;
        if ({flushIF, stallPC, flushID} !== 3'b011) begin
            errors++;
            $display("FAIL lu_branch got %b exp 011", {flushIF, stallPC, flushID});
        end
        tick();
        clear_load_use();
        #1;
        checks++;
        if ({flushIF, stallPC, stallIF, flushID} !== 4'b1000) begin
            errors++;
            $display("FAIL branch_flush got %b exp 1000", {flushIF, stallPC, stallIF, flushID});
        end
        ID_branch_tkn = 1'b0;
        i_dbg_run = 1'b0;
        #1;
        checks++;
        if (stallPC !== 1'b0) begin
            errors++;
            $display("FAIL run_drop_advance stallPC %b exp 0", stallPC);
        end
        tick();
        checks++;
        if ({stallPC, stallIF, stallID} !== 3'b111 || o_stalls !== 32'd3) begin
            errors++;
            $display("FAIL run_to_idle ctrl %b stalls %0d exp 111 3", {stallPC, stallIF, stallID}, o_stalls);
        end
    endtask

    task automatic test_step();
        do_reset();
        i_dbg_step = 1'b1;
        tick();
        i_dbg_step = 1'b0;
        #1;
        checks++;
        if ({stallPC, stallIF, stallID, o_step_done} !== 4'b0000) begin
            errors++;
            $display("FAIL step_advance got %b exp 0000", {stallPC, stallIF, stallID, o_step_done});
        end
        tick();
        checks++;
        if ({stallPC, o_step_done} !== 2'b11 || o_cycles !== 32'd1) begin
            errors++;
            $display("FAIL step_done got %b cycles %0d exp 11 1", {stallPC, o_step_done}, o_cycles);
        end
        tick();
        checks++;
        if ({stallPC, o_step_done} !== 2'b10 || o_cycles !== 32'd1) begin
            errors++;
            $display("FAIL step_pulse_end got %b cycles %0d exp 10 1", {stallPC, o_step_done}, o_cycles);
        end
    endtask

    task automatic test_step_ignored();
        i_dbg_run = 1'b1;
        tick();
        i_dbg_run = 1'b0;
        i_dbg_step = 1'b1;
        tick();
        i_dbg_step = 1'b0;
        tick();
        checks++;
        if ({stallPC, o_step_done} !== 2'b10) begin
            errors++;
            $display("FAIL step_not_queued got %b exp 10", {stallPC, o_step_done});
        end
    endtask

    task automatic test_halt();
        do_reset();
        i_dbg_run = 1'b1;
        tick();
        ID_halt = 1'b1;
        #1;
        checks++;
        if ({stallPC, flushIF, stallID, flushID} !== 4'b1100) begin
            errors++;
            $display("FAIL halt_seen got %b exp 1100", {stallPC, flushIF, stallID, flushID});
        end
        tick();
        ID_halt = 1'b0;
        i_dbg_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({stallPC, flushIF, stallID, o_halted} !== 4'b1100) begin
                errors++;
                $display("FAIL drain_%0d got %b exp 1100", i, {stallPC, flushIF, stallID, o_halted});
            end
            tick();
        end
        checks++;
        if ({o_halted, stallPC, stallIF, stallID, flushIF} !== 5'b11110 || o_cycles !== 32'd4) begin
            errors++;
            $display("FAIL halted got %b cycles %0d exp 11110 4",
                     {o_halted, stallPC, stallIF, stallID, flushIF}, o_cycles);
        end
        i_dbg_run = 1'b1;
        i_dbg_step = 1'b1;
        tick();
        tick();
        checks++;
        if ({o_halted, stallPC} !== 2'b11 || o_cycles !== 32'd4) begin
            errors++;
            $display("FAIL halted_sticky got %b cycles %0d exp 11 4", {o_halted, stallPC}, o_cycles);
        end
    endtask

    task automatic test_halt_lu();
        do_reset();
        i_dbg_run = 1'b1;
        tick();
        ID_halt = 1'b1;
        set_load_use(5'd5, 5'd5);
        #1;
        checks++;
        if ({flushIF, flushID, stallPC} !== 3'b011) begin
            errors++;
            $display("FAIL halt_lu got %b exp 011", {flushIF, flushID, stallPC});
        end
        tick();
        clear_load_use();
        #1;
        checks++;
        if ({flushIF, stallPC, stallIF} !== 3'b110) begin
            errors++;
            $display("FAIL halt_after_lu got %b exp 110", {flushIF, stallPC, stallIF});
        end
    endtask

    task automatic test_reset_in_drain();
        tick();
        ID_halt = 1'b0;
        i_dbg_run = 1'b0;
        #1;
        checks++;
        if (o_cycles !== 32'd2 || flushIF !== 1'b1) begin
            errors++;
            $display("FAIL in_drain cycles %0d flushIF %b exp 2 1", o_cycles, flushIF);
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        checks++;
        if ({stallPC, stallIF, stallID, flushIF, o_halted, o_step_done} !== 6'b111000 ||
            o_cycles !== 32'd0 || o_stalls !== 32'd0) begin
            errors++;
            $display("FAIL drain_reset got %b cycles %0d stalls %0d exp 111000 0 0",
                     {stallPC, stallIF, stallID, flushIF, o_halted, o_step_done}, o_cycles, o_stalls);
        end
        tick();
        tick();
        tick();
        tick();
        checks++;
        if ({o_halted, stallPC} !== 2'b01 || o_cycles !== 32'd0) begin
            errors++;
            $display("FAIL drain_reset_idle got %b cycles %0d exp 01 0", {o_halted, stallPC}, o_cycles);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_stall();
        test_lu_branch();
        test_step();
        test_step_ignored();
        test_halt();
        test_halt_lu();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
